bp_me_wormhole_stream_encode: RTL and testbench

Sequential, parametrised wormhole packet encoder and serializer for BedRock messages. Accepts one message per handshake: message header, data block, destination cord/cid. Computes the wormhole length field from message type and size, then streams the packet onto a coherence or memory NoC link one flit per cycle. It generalises per-channel combinational header encoders to any message class. A data-bearing-type mask and a maximum data size select the class.

---
 rtl/bp_me_wormhole_stream_encode_pkg.sv | 47 ++++
 rtl/bp_me_wormhole_stream_encode_if.sv | 34 +++
 rtl/bp_me_wormhole_len_calc.sv | 31 +++
 rtl/bp_me_wormhole_stream_encode.sv | 115 +++++++++++
 tb/tb_bp_me_wormhole_stream_encode.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_wormhole_stream_encode_pkg.sv
`ifndef BP_ME_WORMHOLE_STREAM_ENCODE_PKG_SV
`define BP_ME_WORMHOLE_STREAM_ENCODE_PKG_SV

`define BP_ME_WORMHOLE_HDR_S(cord_w, len_w, cid_w, hdr_w) \
  typedef struct packed { \
    logic [(hdr_w)-1:0]  msg_hdr; \
    logic [(cid_w)-1:0]  cid; \
    logic [(len_w)-1:0]  len; \
    logic [(cord_w)-1:0] cord; \
  } bp_me_wormhole_hdr_s

package bp_me_wormhole_stream_encode_pkg;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  function automatic int unsigned bp_bedrock_size_to_bytes(bp_bedrock_msg_size_e size);
    return 32'd1 << size;
  endfunction

  function automatic int unsigned cdiv(int unsigned a, int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned bp_me_wormhole_len(int unsigned hdr_w, int unsigned flit_w,
                                                     int unsigned max_bytes, bit data_en,
                                                     bp_bedrock_msg_size_e size);
    int unsigned bytes;
    bytes = 0;
    if (data_en) begin
      bytes = bp_bedrock_size_to_bytes(size);
      if (bytes > max_bytes) bytes = max_bytes;
    end
    return cdiv(hdr_w + 8 * bytes, flit_w) - 1;
  endfunction

endpackage

`endif

// File: rtl/bp_me_wormhole_stream_encode_if.sv
// Message-in / flit-out handshake bundle for the wormhole stream encoder.
// The master modport is the encoder's view; slave is the environment's.
interface bp_me_wormhole_stream_encode_if
    import bp_me_wormhole_stream_encode_pkg::*;
#(
    parameter int unsigned flit_width_p     = 64,
    parameter int unsigned cord_width_p     = 7,
    parameter int unsigned cid_width_p      = 2,
    parameter int unsigned msg_hdr_width_p  = 83,
    parameter int unsigned msg_type_width_p = 4,
    parameter int unsigned max_data_bytes_p = 64
);
    logic [msg_hdr_width_p-1:0]    msg_hdr_i;
    logic [msg_type_width_p-1:0]   msg_type_i;
    bp_bedrock_msg_size_e          msg_size_i;
    logic [8*max_data_bytes_p-1:0] data_i;
    logic [cord_width_p-1:0]       cord_i;
    logic [cid_width_p-1:0]        cid_i;
    logic                          v_i;
    logic                          ready_and_o;
    logic [flit_width_p-1:0]       link_data_o;
    logic                          link_v_o;
    logic                          link_ready_and_i;

    modport master (
        input  msg_hdr_i, msg_type_i, msg_size_i, data_i, cord_i, cid_i, v_i, link_ready_and_i,
        output ready_and_o, link_data_o, link_v_o
    );

    modport slave (
        output msg_hdr_i, msg_type_i, msg_size_i, data_i, cord_i, cid_i, v_i, link_ready_and_i,
        input  ready_and_o, link_data_o, link_v_o
    );
endinterface

// File: rtl/bp_me_wormhole_len_calc.sv
// Combinational wormhole length lookup: (msg_type, size) -> len field, from a
// per-size constant table, so no runtime divider is built.
module bp_me_wormhole_len_calc
    import bp_me_wormhole_stream_encode_pkg::*;
#(
    parameter int unsigned flit_width_p     = 64,
    parameter int unsigned wh_hdr_width_p   = 96,
    parameter int unsigned len_width_p      = 4,
    parameter int unsigned msg_type_width_p = 4,
    parameter int unsigned max_data_bytes_p = 64,
    parameter logic [(1<<msg_type_width_p)-1:0] data_type_mask_p = 16'h0006
)
(
    input  logic [msg_type_width_p-1:0] msg_type_i,
    input  bp_bedrock_msg_size_e        msg_size_i,
    output logic [len_width_p-1:0]      len_o
);
    localparam logic [len_width_p-1:0] nodata_len_lp = len_width_p'(bp_me_wormhole_len(
        wh_hdr_width_p, flit_width_p, max_data_bytes_p, 1'b0, e_bedrock_msg_size_1));

    logic [len_width_p-1:0] len_tbl [8];

    for (genvar s = 0; s < 8; s++) begin : g_len_tbl
        assign len_tbl[s] = len_width_p'(bp_me_wormhole_len(wh_hdr_width_p, flit_width_p,
            max_data_bytes_p, 1'b1, bp_bedrock_msg_size_e'(3'(s))));
    end

    always_comb begin
        len_o = data_type_mask_p[msg_type_i] ? len_tbl[msg_size_i] : nodata_len_lp;
    end
endmodule

// File: rtl/bp_me_wormhole_stream_encode.sv
module bp_me_wormhole_stream_encode
  import bp_me_wormhole_stream_encode_pkg::*;
#(
  parameter int unsigned flit_width_p     = 64,
  parameter int unsigned cord_width_p     = 7,
  parameter int unsigned len_width_p      = 4,
  parameter int unsigned cid_width_p      = 2,
  parameter int unsigned msg_hdr_width_p  = 83,
  parameter int unsigned msg_type_width_p = 4,
  parameter int unsigned max_data_bytes_p = 64,
  parameter logic [(1<<msg_type_width_p)-1:0] data_type_mask_p = 16'h0006
)
(
  input logic clk_i,
  input logic reset_n_i,
  bp_me_wormhole_stream_encode_if.master bus
);
  localparam int unsigned wh_hdr_width_lp = cord_width_p + len_width_p + cid_width_p + msg_hdr_width_p;
  localparam int unsigned data_width_lp   = 8 * max_data_bytes_p;
  localparam int unsigned max_flits_lp    = cdiv(wh_hdr_width_lp + data_width_lp, flit_width_p);
  localparam int unsigned pkt_width_lp    = max_flits_lp * flit_width_p;

  `BP_ME_WORMHOLE_HDR_S(cord_width_p, len_width_p, cid_width_p, msg_hdr_width_p);

  typedef enum logic {e_ready, e_send} state_e;

  state_e                                    state_q, state_d;
  logic [len_width_p-1:0]                    cnt_q, cnt_d, len_q, len_d, msg_len;
  logic [max_flits_lp-1:0][flit_width_p-1:0] pkt_q, pkt_d;
  bp_me_wormhole_hdr_s                       wh_hdr;
  logic [data_width_lp-1:0]                  data_masked;
  logic                                      last_flit, capture;
  int unsigned                               nbytes;

  bp_me_wormhole_len_calc #(
    .flit_width_p    (flit_width_p),
    .wh_hdr_width_p  (wh_hdr_width_lp),
    .len_width_p     (len_width_p),
    .msg_type_width_p(msg_type_width_p),
    .max_data_bytes_p(max_data_bytes_p),
    .data_type_mask_p(data_type_mask_p)
  ) len_calc (
    .msg_type_i(bus.msg_type_i),
    .msg_size_i(bus.msg_size_i),
    .len_o     (msg_len)
  );

  always_comb begin
    nbytes = 0;
    if (data_type_mask_p[bus.msg_type_i]) begin
      nbytes = bp_bedrock_size_to_bytes(bus.msg_size_i);
      if (nbytes > max_data_bytes_p) nbytes = max_data_bytes_p;
    end
    data_masked = '0;
    for (int unsigned b = 0; b < max_data_bytes_p; b++) begin
      data_masked[8*b +: 8] = (b < nbytes) ? bus.data_i[8*b +: 8] : 8'h00;
    end
    wh_hdr = '{msg_hdr: bus.msg_hdr_i, cid: bus.cid_i, len: msg_len, cord: bus.cord_i};
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    pkt_d           = pkt_q;
    capture         = 1'b0;
    bus.ready_and_o = 1'b0;
    bus.link_v_o    = 1'b0;
    last_flit       = (cnt_q == len_q);
    unique case (state_q)
      e_ready: begin
        bus.ready_and_o = 1'b1;
        capture         = bus.v_i;
        if (bus.v_i) state_d = e_send;
      end
      e_send: begin
        bus.link_v_o    = 1'b1;
        bus.ready_and_o = bus.link_ready_and_i & last_flit;
        if (bus.link_ready_and_i) begin
          if (!last_flit) begin
            cnt_d = cnt_q + 1'b1;
          end else if (bus.v_i) begin
            capture = 1'b1;
          end else begin
            state_d = e_ready;
            cnt_d   = '0;
          end
        end
      end
    endcase
    if (capture) begin
      cnt_d = '0;
      len_d = msg_len;
      pkt_d = pkt_width_lp'({data_masked, wh_hdr});
    end
  end

  always_comb begin
    bus.link_data_o = pkt_q[cnt_q];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
    end
  end
endmodule

// File: tb/tb_bp_me_wormhole_stream_encode.sv
// Self-checking bench for bp_me_wormhole_stream_encode: vector table plus hand-written
// backpressure, chaining and mid-packet reset sequences, all checked via a flit scoreboard.
module tb_bp_me_wormhole_stream_encode;
    import bp_me_wormhole_stream_encode_pkg::*;

    localparam int unsigned PW = 640;

    typedef struct {
        logic [3:0]  mtype;
        logic [2:0]  size;
        logic [6:0]  cord;
        logic [1:0]  cid;
        int unsigned exp_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   hs_cyc = 0;
    int   first_v_cyc = 0;
    int   last_pop_cyc = 0;
    logic [63:0] first_data = '0;
    logic [63:0] exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_me_wormhole_stream_encode_if bus ();

    bp_me_wormhole_stream_encode dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference packet image built straight from the documented layout.
    task automatic push_expected();
        logic [PW-1:0] pkt;
        int unsigned nb, ln, sz;
        logic [31:0] ln_v;
        sz = int'(bus.msg_size_i);
        nb = 0;
        if (bus.msg_type_i == 4'd1 || bus.msg_type_i == 4'd2) nb = ((1 << sz) > 64) ? 64 : (1 << sz);
        ln = (96 + 8 * nb + 63) / 64 - 1;
        ln_v = ln;
        pkt = '0;
        pkt[6:0]   = bus.cord_i;
        pkt[10:7]  = ln_v[3:0];
        pkt[12:11] = bus.cid_i;
        pkt[95:13] = bus.msg_hdr_i;
        for (int unsigned b = 0; b < nb; b++) pkt[96 + 8*b +: 8] = bus.data_i[8*b +: 8];
        for (int unsigned k = 0; k <= ln; k++) exp_q.push_back(pkt[64*k +: 64]);
    endtask

    task automatic monitor();
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.link_v_o && !prev_v) begin
                first_v_cyc = cyc;
                first_data  = bus.link_data_o;
            end
            prev_v = bus.link_v_o;
            if (bus.link_v_o && bus.link_ready_and_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL flit_unexpected: got %h expected no flit", bus.link_data_o);
                end else begin
                    check("flit", bus.link_data_o, exp_q.pop_front());
                end
                pops++;
                last_pop_cyc = cyc;
            end
            if (bus.v_i && bus.ready_and_o) begin
                hs_cyc = cyc;
                push_expected();
            end
        end
    endtask

    task automatic randomize_inputs();
        logic [95:0] h;
        h = {$urandom, $urandom, $urandom};
        bus.msg_hdr_i  = h[82:0];
        bus.msg_type_i = 4'($urandom);
        bus.msg_size_i = bp_bedrock_msg_size_e'(3'($urandom));
        bus.cord_i     = 7'($urandom);
        bus.cid_i      = 2'($urandom);
        for (int unsigned w = 0; w < 16; w++) bus.data_i[32*w +: 32] = $urandom;
    endtask

    task automatic drive(input vec_t v);
        logic [95:0] h;
        h = {$urandom, $urandom, $urandom};
        bus.msg_hdr_i  = h[82:0];
        bus.msg_type_i = v.mtype;
        bus.msg_size_i = bp_bedrock_msg_size_e'(v.size);
        bus.cord_i     = v.cord;
        bus.cid_i      = v.cid;
        for (int unsigned b = 0; b < 64; b++) bus.data_i[8*b +: 8] = 8'(b);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready_and_o && n < 50);
        if (!bus.ready_and_o) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready_and_o expected handshake within 50 cycles", name);
        end
    endtask

    // Returns one cycle after the handshake, with v_i dropped and inputs scrambled.
    task automatic send(input vec_t v);
        @(posedge clk); #1;
        drive(v);
        bus.v_i = 1'b1;
        wait_ready("send");
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        randomize_inputs();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((exp_q.size() != 0 || bus.link_v_o) && n < 100);
        if (exp_q.size() != 0 || bus.link_v_o) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: got %0d flits pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        vec_t va, vb;
        int   p0, h1, h2;
        logic [63:0] held;

        vecs[0] = '{mtype: 4'd0, size: 3'd6, cord: 7'd5,  cid: 2'd1, exp_len: 1};
        vecs[1] = '{mtype: 4'd1, size: 3'd6, cord: 7'd3,  cid: 2'd2, exp_len: 9};
        vecs[2] = '{mtype: 4'd2, size: 3'd0, cord: 7'd9,  cid: 2'd3, exp_len: 1};
        vecs[3] = '{mtype: 4'd2, size: 3'd7, cord: 7'd127, cid: 2'd0, exp_len: 9};
        vecs[4] = '{mtype: 4'd1, size: 3'd3, cord: 7'd64, cid: 2'd1, exp_len: 2};
        vecs[5] = '{mtype: 4'd2, size: 3'd4, cord: 7'd17, cid: 2'd2, exp_len: 3};
        vecs[6] = '{mtype: 4'd1, size: 3'd5, cord: 7'd33, cid: 2'd3, exp_len: 5};
        vecs[7] = '{mtype: 4'd3, size: 3'd6, cord: 7'd1,  cid: 2'd1, exp_len: 1};

        bus.v_i = 1'b0;
        bus.link_ready_and_i = 1'b1;
        randomize_inputs();
        fork
            monitor();
        join_none

        #12;
        check("reset_link_v", 64'(bus.link_v_o), 64'd0);
        check("reset_link_data", bus.link_data_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 64'(bus.ready_and_o), 64'd1);
        check("post_reset_link_v", 64'(bus.link_v_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            p0 = pops;
            send(vecs[i]);
            wait_idle("vec");
            check("vec_len_field", 64'(first_data[10:7]), 64'(vecs[i].exp_len));
            check("vec_cord_field", 64'(first_data[6:0]), 64'(vecs[i].cord));
            check("vec_nflits", 64'(pops - p0), 64'(vecs[i].exp_len + 1));
            check("vec_latency", 64'(first_v_cyc - hs_cyc), 64'd1);
        end

        // Backpressure: stall flit 4 of a 10-flit packet for three cycles.
        p0 = pops;
        send(vecs[1]);
        h1 = hs_cyc;
        repeat (4) @(posedge clk);
        #1;
        bus.link_ready_and_i = 1'b0;
        held = bus.link_data_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.link_data_o, held);
            check("bp_hold_v", 64'(bus.link_v_o), 64'd1);
            check("bp_ready_low", 64'(bus.ready_and_o), 64'd0);
            @(posedge clk); #1;
        end
        bus.link_ready_and_i = 1'b1;
        wait_idle("bp");
        check("bp_total_cycles", 64'(last_pop_cyc - h1), 64'd13);
        check("bp_nflits", 64'(pops - p0), 64'd10);

        // Back-to-back: second handshake lands on the first packet's last flit.
        va = vecs[0];
        vb = vecs[2];
        p0 = pops;
        @(posedge clk); #1;
        drive(va);
        bus.v_i = 1'b1;
        wait_ready("b2b_first");
        h1 = hs_cyc;
        @(posedge clk); #1;
        drive(vb);
        @(negedge clk);
        check("b2b_ready_mid", 64'(bus.ready_and_o), 64'd0);
        wait_ready("b2b_second");
        h2 = cyc;
        check("b2b_hs_gap", 64'(h2 - h1), 64'd2);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        randomize_inputs();
        wait_idle("b2b");
        check("b2b_last_flit_cycle", 64'(last_pop_cyc - h1), 64'd4);
        check("b2b_nflits", 64'(pops - p0), 64'd4);

        // Reset in the middle of a packet drops it immediately.
        send(vecs[1]);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_link_v", 64'(bus.link_v_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 64'(bus.ready_and_o), 64'd1);
        check("rst_release_link_v", 64'(bus.link_v_o), 64'd0);
        check("rst_release_data", bus.link_data_o, 64'd0);
        p0 = pops;
        send(vecs[4]);
        wait_idle("after_rst");
        check("after_rst_len", 64'(first_data[10:7]), 64'd2);
        check("after_rst_nflits", 64'(pops - p0), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
